uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter for the Segway serial links. It adds configurable data width, baud divisor, parity and stop-bit count, plus an explicit busy flag, while keeping the trmt/tx_done handshake. It sits beside the existing UART receivers and is driven by the command/telemetry logic. Frames are LSB-first, with an idle-high line.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9.
BAUD_DIV, 2604, clocks per bit; legal >=2 (2604 = 50MHz/19200).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
trmt  input  1  single-cycle request to transmit tx_data.
tx_data  input  DATA_BITS  payload; sampled only in the cycle trmt is accepted.
TX  output  1  serial line; idles high.
tx_done  output  1  set/reset flag; high once a frame completes.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, TX=1, tx_done=0, busy=0, counters cleared. Reset mid-frame aborts the frame; TX is 1 after that edge.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: trmt=1 is accepted. tx_data is latched, tx_done clears, and the state goes to START. TX=0 and busy=1 from the next cycle (1-cycle latency).
- Bit timing: baud_cnt loads BAUD_DIV-1 at each bit start and decrements each clk. At baud_cnt==0 the bit ends, so every bit lasts exactly BAUD_DIV clocks.
- START: one bit of 0, then DATA.
- DATA: shifts out DATA_BITS bits LSB first; bit_cnt counts 0..DATA_BITS-1. Goes to PAR if PARITY!=0, else STOP.
- PAR: one bit. Even mode sends ^data; odd mode sends ~^data. Parity is computed from the latched data, not the live tx_data.
- STOP: STOP_BITS bits of 1. On the end of the last stop bit: state=IDLE, busy=0, tx_done=1 in the same edge.
- Frame length: BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clocks, from the first TX=0 cycle to the tx_done rise.
- trmt while busy=1 is ignored; the frame is not corrupted and tx_done is not cleared.
- trmt in the same cycle tx_done rises: busy is still 1, so the request is ignored.
- trmt in the first IDLE cycle after that is accepted, giving back-to-back frames with no extra idle bit.
- tx_done stays high until the next accepted trmt.
- Illegal parameter values are caught by an elaboration-time check (generate-time error); no runtime handling.

Optional Feature:
UART_TX_BREAK_EN.
- Defined: adds input brk (1 bit).
  - In IDLE with brk=1: TX=0 and busy=1, held while brk stays high; trmt is ignored.
  - On brk falling: TX=1 for one full bit time (BAUD_DIV clocks), then IDLE.
  - brk asserted mid-frame has no effect until the frame ends.
  - tx_done is unaffected by breaks.
- Undefined: no brk port; the logic is absent.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t.
  - parity localparams PAR_NONE/PAR_EVEN/PAR_ODD.
  - function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- One sub-module uart_baud_tick(BAUD_DIV):
  - Inputs clk, rst_n, clr, en.
  - Output tick, high when the count is 0.
  - Reused by the receiver rework.

Test Plan:
- DATA_BITS=8, BAUD_DIV=4, PARITY=1, STOP_BITS=1; trmt with 8'hA5:
  - TX bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks.
  - tx_done rises exactly 44 clocks after the first TX=0 cycle.
- Same settings with PARITY=2, data 8'h01: parity bit = 0 (odd count already 1); frame is 44 clocks.
- DATA_BITS=7, PARITY=0, STOP_BITS=2, BAUD_DIV=3, data 7'h55:
  - Start, 1010101 LSB-first, then 2 stop bits.
  - Frame is 30 clocks; busy falls with the tx_done rise.
- Pulse trmt mid-frame with a different tx_data: the frame is unchanged and tx_done stays low until the original frame ends. A second trmt one cycle after tx_done rises starts the next frame (TX=0 on the following cycle).
- Assert rst_n=0 for 1 cycle during DATA: TX=1, busy=0, tx_done=0 after the edge. A subsequent trmt sends a full clean frame.
- UART_TX_BREAK_EN defined:
  - brk high 20 clocks in IDLE: TX=0 throughout.
  - After brk falls: TX=1 for BAUD_DIV clocks, then busy=0.
  - trmt during the break is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: transmitter state encoding, parity modes, frame sizing.
// States BRK/BRK_END are used only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK,
    BRK_END
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits on the line per frame: start + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high while the down-counter sits at zero.
// clr reloads BAUD_DIV-1; with en high the counter decrements and wraps on tick.
module uart_baud_tick #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: LSB-first frames, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input that holds the line low between frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 2604,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 TX,
  output logic                 tx_done,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_cfg: BAUD_DIV must be >= 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  tx_state_t            state_q, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic [3:0]           bit_cnt_q, bit_cnt_n;
  logic                 stop_q, stop_n;
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;
  logic                 busy_q, busy_n;
  logic                 clr;
  logic                 tick;
  logic                 par_bit;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (busy_q),
    .tick (tick)
  );

  // Parity comes from the copy latched at accept; sh_q is consumed while shifting.
  assign par_bit = (PARITY == PAR_ODD) ? ~^data_q : ^data_q;

  always_comb begin
    state_n   = state_q;
    data_n    = data_q;
    sh_n      = sh_q;
    bit_cnt_n = bit_cnt_q;
    stop_n    = stop_q;
    tx_n      = tx_q;
    done_n    = done_q;
    busy_n    = busy_q;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_n = BRK;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end else
`endif
        if (trmt) begin
          state_n   = START;
          data_n    = tx_data;
          sh_n      = tx_data;
          bit_cnt_n = '0;
          stop_n    = 1'b0;
          tx_n      = 1'b0;
          done_n    = 1'b0;
          busy_n    = 1'b1;
          clr       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = sh_q[0];
          sh_n      = sh_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_n = PAR;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              stop_n  = 1'b0;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt_q + 4'd1;
            tx_n      = sh_q[0];
            sh_n      = sh_q >> 1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_n = STOP;
          stop_n  = 1'b0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
          tx_n = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        // The trailing high bit restarts bit timing from the brk falling edge.
        if (!brk) begin
          state_n = BRK_END;
          tx_n    = 1'b1;
          clr     = 1'b1;
        end
      end
      BRK_END: begin
        if (tick) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      sh_q      <= sh_n;
      bit_cnt_q <= bit_cnt_n;
      stop_q    <= stop_n;
      tx_q      <= tx_n;
      done_q    <= done_n;
      busy_q    <= busy_n;
    end
  end

  assign TX      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations driven side by side against a frame model.
// Break scenarios are exercised when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] trmt_v = '0;
  logic [7:0] dat_a = '0;
  logic [7:0] dat_b = '0;
  logic [6:0] dat_c = '0;
`ifdef UART_TX_BREAK_EN
  logic [2:0] brk_v = '0;
`endif
  wire  [2:0] tx_v, done_v, busy_v;

  int n_tests = 0;
  int n_fail  = 0;

  int div_c[3] = '{4, 4, 3};
  int nb_c[3]  = '{8, 8, 7};
  int par_c[3] = '{1, 2, 0};
  int stp_c[3] = '{1, 1, 2};

  logic exp_q[$];

  uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[0]), .tx_data(dat_a),
`ifdef UART_TX_BREAK_EN
    .brk(brk_v[0]),
`endif
    .TX(tx_v[0]), .tx_done(done_v[0]), .busy(busy_v[0]));

  uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[1]), .tx_data(dat_b),
`ifdef UART_TX_BREAK_EN
    .brk(brk_v[1]),
`endif
    .TX(tx_v[1]), .tx_done(done_v[1]), .busy(busy_v[1]));

  uart_tx_cfg #(.DATA_BITS(7), .BAUD_DIV(3), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[2]), .tx_data(dat_c),
`ifdef UART_TX_BREAK_EN
    .brk(brk_v[2]),
`endif
    .TX(tx_v[2]), .tx_done(done_v[2]), .busy(busy_v[2]));

  task automatic set_in(input int idx, input logic t, input logic [8:0] d);
    trmt_v[idx] = t;
    case (idx)
      0:       dat_a = d[7:0];
      1:       dat_b = d[7:0];
      default: dat_c = d[6:0];
    endcase
  endtask

  // Reference frame, one entry per bit time: start, payload LSB-first, parity, stop bits.
  task automatic build_frame(input int idx, input logic [8:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb_c[idx]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_c[idx] == 1) exp_q.push_back((ones % 2) == 1);
    if (par_c[idx] == 2) exp_q.push_back((ones % 2) == 0);
    for (int i = 0; i < stp_c[idx]; i++) exp_q.push_back(1'b1);
  endtask

  // Runs at negedges; n=0 is the first cycle the start bit is on the line.
  task automatic run_frame(input int idx, input logic [8:0] d, input bit do_pulse,
                           input bit inject_mid, input bit chain, input logic [8:0] d2);
    int div, len;
    div = div_c[idx];
    build_frame(idx, d);
    len = frame_bits(nb_c[idx], par_c[idx], stp_c[idx]) * div;
    if (do_pulse) begin
      set_in(idx, 1'b1, d);
      @(negedge clk);
      set_in(idx, 1'b0, 9'($urandom));
    end
    for (int n = 0; n < len; n++) begin
      n_tests++;
      if (tx_v[idx] !== exp_q[n / div]) begin
        n_fail++;
        $display("FAIL frame_tx idx=%0d data=%h n=%0d got=%b exp=%b", idx, d, n, tx_v[idx], exp_q[n / div]);
      end
      n_tests++;
      if ({done_v[idx], busy_v[idx]} !== 2'b01) begin
        n_fail++;
        $display("FAIL frame_flags idx=%0d n=%0d got done,busy=%b%b exp=01", idx, n, done_v[idx], busy_v[idx]);
      end
      if (chain && n == len - 1)           set_in(idx, 1'b1, d2);
      else if (inject_mid && n == len / 2) set_in(idx, 1'b1, ~d);
      else                                 set_in(idx, 1'b0, 9'($urandom));
      @(negedge clk);
    end
    n_tests++;
    if ({tx_v[idx], done_v[idx], busy_v[idx]} !== 3'b110) begin
      n_fail++;
      $display("FAIL frame_end idx=%0d got tx,done,busy=%b%b%b exp=110", idx, tx_v[idx], done_v[idx], busy_v[idx]);
    end
    if (chain) begin
      @(negedge clk);
      set_in(idx, 1'b0, 9'($urandom));
    end
  endtask

  task automatic check_idle(input int idx, input logic done_exp, input string tag);
    n_tests++;
    if ({tx_v[idx], done_v[idx], busy_v[idx]} !== {1'b1, done_exp, 1'b0}) begin
      n_fail++;
      $display("FAIL %s idx=%0d got tx,done,busy=%b%b%b exp=1%b0", tag, idx, tx_v[idx], done_v[idx], busy_v[idx], done_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, 1'b0, "reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, 1'b0, "post_reset");
  endtask

  task automatic test_fixed();
    run_frame(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0);
    run_frame(1, 9'h001, 1'b1, 1'b0, 1'b0, 9'h0);
    run_frame(2, 9'h055, 1'b1, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic test_random();
    int idx, gap;
    for (int k = 0; k < 9; k++) begin
      idx = $urandom_range(0, 2);
      run_frame(idx, 9'($urandom), 1'b1, 1'b0, 1'b0, 9'h0);
      gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_idle(idx, 1'b1, "done_hold");
      end
    end
  endtask

  task automatic test_ignore_mid();
    for (int i = 0; i < 3; i++) begin
      run_frame(i, 9'($urandom), 1'b1, 1'b1, 1'b0, 9'h0);
      @(negedge clk);
      check_idle(i, 1'b1, "after_ignored");
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] d1, d2;
    for (int i = 0; i < 3; i++) begin
      d1 = 9'($urandom);
      d2 = 9'($urandom);
      run_frame(i, d1, 1'b1, 1'b0, 1'b1, d2);
      run_frame(i, d2, 1'b0, 1'b0, 1'b0, 9'h0);
    end
  endtask

  task automatic test_reset_mid();
    set_in(0, 1'b1, 9'h03C);
    @(negedge clk);
    set_in(0, 1'b0, 9'($urandom));
    repeat (div_c[0] * 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, 1'b0, "reset_mid");
    @(negedge clk);
    check_idle(0, 1'b0, "reset_mid_hold");
    run_frame(0, 9'($urandom), 1'b1, 1'b0, 1'b0, 9'h0);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    brk_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b011) begin
        n_fail++;
        $display("FAIL brk_hold i=%0d got tx,busy,done=%b%b%b exp=011", i, tx_v[0], busy_v[0], done_v[0]);
      end
      set_in(0, (i == 5 || i == 12), 9'($urandom));
    end
    set_in(0, 1'b0, 9'h0);
    brk_v[0] = 1'b0;
    for (int m = 0; m < div_c[0]; m++) begin
      @(negedge clk);
      n_tests++;
      if ({tx_v[0], busy_v[0]} !== 2'b11) begin
        n_fail++;
        $display("FAIL brk_tail m=%0d got tx,busy=%b%b exp=11", m, tx_v[0], busy_v[0]);
      end
    end
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      check_idle(0, 1'b1, "brk_end");
    end
    run_frame(0, 9'($urandom), 1'b1, 1'b0, 1'b0, 9'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
